fdtd_hy_sched: RTL and testbench

FDTD_HY_SCHED -- requirements
Module: fdtd_hy_sched

---
 rtl/fdtd_hy_sched.sv | 108 ++++++++++
 tb/tb_fdtd_hy_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdtd_hy_sched.sv
// Read/write scheduler for one FDTD Hy line sweep: primes Ez, streams Ez/Hy reads,
// and retires Hy write-backs through a tag pipeline matched to the datapath latency.
module fdtd_hy_sched #(
    parameter int FDTD_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int PIPE_LAT        = 6
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      cell_num,
    input  logic [FDTD_DATA_WIDTH-1:0] Hy_n_i,
    output logic                       busy,
    output logic                       done,
    output logic                       clken,
    output logic                       ez_rd_en,
    output logic [ADDR_WIDTH-1:0]      ez_rd_addr,
    output logic                       hy_rd_en,
    output logic [ADDR_WIDTH-1:0]      hy_rd_addr,
    output logic                       hy_wr_en,
    output logic [ADDR_WIDTH-1:0]      hy_wr_addr,
    output logic [FDTD_DATA_WIDTH-1:0] hy_wr_data,
    output logic [2:0]                 state_dbg
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PRIME = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] n_q;
    logic [ADDR_WIDTH-1:0] ez_addr_q;
    logic [ADDR_WIDTH-1:0] hy_addr_q;
    logic [PIPE_LAT-1:0]   vld_q;
    logic [ADDR_WIDTH-1:0] tag_q [PIPE_LAT];
    logic                  run_last;
    logic                  pipe_tail_empty;

    // hy_addr_q doubles as the RUN cycle index k
    assign run_last        = (hy_addr_q == (n_q - ONE));
    // The entry leaving this cycle is the only one that may remain when DRAIN ends
    assign pipe_tail_empty = ~|vld_q[PIPE_LAT-2:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (cell_num != '0) ? PRIME : DONE;
            PRIME:   state_nxt = RUN;
            RUN:     if (run_last) state_nxt = DRAIN;
            DRAIN:   if (pipe_tail_empty) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            n_q       <= '0;
            ez_addr_q <= '0;
            hy_addr_q <= '0;
            vld_q     <= '0;
        end else begin
            state <= state_nxt;
            vld_q <= {vld_q[PIPE_LAT-2:0], (state == RUN)};
            if (state == IDLE && start && cell_num != '0) begin
                n_q       <= cell_num;
                ez_addr_q <= '0;
            end
            // Hy address is only loaded when RUN begins so it holds through PRIME
            if (state == PRIME) begin
                ez_addr_q <= ONE;
                hy_addr_q <= '0;
            end
            if (state == RUN && !run_last) begin
                ez_addr_q <= ez_addr_q + ONE;
                hy_addr_q <= hy_addr_q + ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= hy_addr_q;
            for (int i = 1; i < PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign clken      = (state == PRIME) || (state == RUN) || (state == DRAIN);
    assign ez_rd_en   = (state == PRIME) || (state == RUN);
    assign ez_rd_addr = ez_addr_q;
    assign hy_rd_en   = (state == RUN);
    assign hy_rd_addr = hy_addr_q;
    assign hy_wr_en   = vld_q[PIPE_LAT-1];
    assign hy_wr_addr = tag_q[PIPE_LAT-1];
    assign hy_wr_data = Hy_n_i;
    assign state_dbg  = state;

endmodule

// File: tb/tb_fdtd_hy_sched.sv
// Bench for fdtd_hy_sched: sweep-timing model, Ez/Hy memory + datapath model,
// directed scenarios and a randomized start/reset phase.
module tb_fdtd_hy_sched;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int PL  = 6;
    localparam int MEM = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] cell_num = '0;
    logic [DW-1:0] Hy_n_i = '0;
    logic          busy, done, clken, ez_rd_en, hy_rd_en, hy_wr_en;
    logic [AW-1:0] ez_rd_addr, hy_rd_addr, hy_wr_addr;
    logic [DW-1:0] hy_wr_data;
    logic [2:0]    state_dbg;

    fdtd_hy_sched #(.FDTD_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PIPE_LAT(PL)) dut (
        .CLK(CLK), .RST(RST), .start(start), .cell_num(cell_num), .Hy_n_i(Hy_n_i),
        .busy(busy), .done(done), .clken(clken),
        .ez_rd_en(ez_rd_en), .ez_rd_addr(ez_rd_addr),
        .hy_rd_en(hy_rd_en), .hy_rd_addr(hy_rd_addr),
        .hy_wr_en(hy_wr_en), .hy_wr_addr(hy_wr_addr), .hy_wr_data(hy_wr_data),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int t0       = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memories and golden Hy update ----------------
    logic [DW-1:0] ez_mem  [MEM];
    logic [DW-1:0] hy_mem  [MEM];
    logic [DW-1:0] hy_gold [MEM];

    typedef struct {
        int            due;
        logic [DW-1:0] val;
    } dp_t;
    dp_t           dp_q[$];
    logic [DW-1:0] ez_prev = '0;

    // Datapath stand-in: result of each Hy read appears on Hy_n_i PL cycles later
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            while (dp_q.size() > 0 && dp_q[0].due < cyc) void'(dp_q.pop_front());
            if (dp_q.size() > 0 && dp_q[0].due == cyc) Hy_n_i = dp_q.pop_front().val;
            else Hy_n_i = $urandom;
        end
    end

    // ---------------- behavioural model + scoreboard ----------------
    logic          m_active = 1'b0;
    int            m_c0 = 0;
    int            m_n = 0;
    logic [AW-1:0] m_last_ez = '0;
    logic [AW-1:0] m_last_hy = '0;
    logic [AW-1:0] exp_q[$];

    always @(negedge CLK) begin
        int            d;
        int            done_d;
        logic          idle_now;
        logic          e_busy, e_done, e_clk, e_ez, e_hy, e_wr;
        logic [AW-1:0] e_eza, e_hya, e_wra;
        dp_t           dp;
        if (cyc >= 1) begin
            d = cyc - m_c0;
            done_d = (m_n == 0) ? 1 : m_n + 2 + PL;
            e_busy = 1'b0; e_done = 1'b0; e_clk = 1'b0;
            e_ez = 1'b0; e_hy = 1'b0; e_wr = 1'b0;
            e_eza = m_last_ez; e_hya = m_last_hy; e_wra = '0;
            if (m_active) begin
                e_busy = 1'b1;
                e_done = (d == done_d);
                if (m_n > 0) begin
                    e_clk = (d >= 1) && (d < done_d);
                    if (d == 1) begin
                        e_ez = 1'b1; e_eza = '0;
                    end else if (d >= 2 && d <= m_n + 1) begin
                        e_ez = 1'b1; e_eza = AW'(d - 1);
                        e_hy = 1'b1; e_hya = AW'(d - 2);
                    end
                    if (d >= 2 + PL && d <= m_n + 1 + PL) begin
                        e_wr = 1'b1; e_wra = AW'(d - 2 - PL);
                    end
                end
            end

            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("clken", clken, e_clk);
            chk("ez_rd_en", ez_rd_en, e_ez);
            chk("ez_rd_addr", ez_rd_addr, e_eza);
            chk("hy_rd_en", hy_rd_en, e_hy);
            chk("hy_rd_addr", hy_rd_addr, e_hya);
            chk("hy_wr_en", hy_wr_en, e_wr);
            if (e_wr) begin
                chk("hy_wr_addr", hy_wr_addr, e_wra);
                chk("hy_wr_data", hy_wr_data, hy_gold[e_wra]);
            end
            chk("wr_unexpected", (hy_wr_en === 1'b1) && (exp_q.size() == 0), 1'b0);
            if (hy_wr_en === 1'b1 && exp_q.size() > 0) chk("wr_order", hy_wr_addr, exp_q.pop_front());
            if (e_done) chk("wr_left_at_done", exp_q.size(), 0);

            if (hy_rd_en === 1'b1) begin
                dp.due = cyc + PL;
                dp.val = hy_mem[hy_rd_addr] + ez_mem[ez_rd_addr] - ez_prev;
                dp_q.push_back(dp);
            end
            if (ez_rd_en === 1'b1) ez_prev = ez_mem[ez_rd_addr];

            if (e_ez) m_last_ez = e_eza;
            if (e_hy) m_last_hy = e_hya;
            idle_now = !m_active;
            if (m_active && d == done_d) m_active = 1'b0;
            if (RST) begin
                m_active = 1'b0; m_last_ez = '0; m_last_hy = '0;
                exp_q.delete();
                dp_q.delete();
            end else if (idle_now && start) begin
                m_active = 1'b1; m_c0 = cyc; m_n = int'(cell_num);
                for (int k = 0; k < m_n; k++) exp_q.push_back(AW'(k));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input int n);
        @(posedge CLK); #1;
        start = 1'b1; cell_num = AW'(n); t0 = cyc;
        @(posedge CLK); #1;
        start = 1'b0; cell_num = AW'($urandom_range(0, 31));
    endtask

    task automatic observe(input int budget, output int done_off, output int first_wr,
                           output int n_wr, output int n_ez, output int busy_n,
                           output logic [AW-1:0] last_ez);
        done_off = -1; first_wr = -1; n_wr = 0; n_ez = 0; busy_n = 0; last_ez = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (busy) busy_n++;
            if (hy_wr_en) begin
                n_wr++;
                if (first_wr < 0) first_wr = cyc - t0;
            end
            if (ez_rd_en) begin
                n_ez++; last_ez = ez_rd_addr;
            end
            if (done) done_off = cyc - t0;
            if (!busy) return;
        end
        chk("observe_timeout", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int            done_off, first_wr, n_wr, n_ez, busy_n, n_done;
        logic [AW-1:0] last_ez;
        for (int i = 0; i < MEM; i++) begin
            ez_mem[i] = $urandom;
            hy_mem[i] = $urandom;
        end
        for (int i = 0; i < MEM - 1; i++) hy_gold[i] = hy_mem[i] + ez_mem[i+1] - ez_mem[i];
        hy_gold[MEM-1] = '0;

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_state", state_dbg, 3'd0);
        chk("reset_wr_addr", hy_wr_addr, '0);
        RST = 1'b0;
        repeat (2) @(posedge CLK);

        // N=4 reference timing
        do_start(4);
        observe(40, done_off, first_wr, n_wr, n_ez, busy_n, last_ez);
        chk("n4_done_cycle", done_off, 12);
        chk("n4_first_write_cycle", first_wr, 8);
        chk("n4_write_count", n_wr, 4);
        chk("n4_ez_reads", n_ez, 5);
        chk("n4_busy_cycles", busy_n, 12);
        chk("n4_last_ez", last_ez, 4);

        // N=0: immediate done
        do_start(0);
        observe(10, done_off, first_wr, n_wr, n_ez, busy_n, last_ez);
        chk("n0_done_cycle", done_off, 1);
        chk("n0_writes", n_wr, 0);
        chk("n0_ez_reads", n_ez, 0);

        // start re-pulsed during RUN
        do_start(5);
        @(posedge CLK); #1;
        start = 1'b1; cell_num = AW'(7);
        @(posedge CLK); #1;
        start = 1'b0;
        observe(40, done_off, first_wr, n_wr, n_ez, busy_n, last_ez);
        chk("restart_writes", n_wr, 5);
        chk("restart_done_cycle", done_off, 13);

        // reset during DRAIN of an N=8 sweep
        do_start(8);
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_clken", clken, 1'b0);
        chk("abort_ez_addr", ez_rd_addr, '0);
        chk("abort_hy_addr", hy_rd_addr, '0);
        n_wr = 0; n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (hy_wr_en) n_wr++;
            if (done) n_done++;
        end
        chk("abort_writes_after", n_wr, 0);
        chk("abort_done_after", n_done, 0);
        do_start(3);
        observe(40, done_off, first_wr, n_wr, n_ez, busy_n, last_ez);
        chk("post_reset_done_cycle", done_off, 11);
        chk("post_reset_writes", n_wr, 3);

        // back-to-back: start in DONE ignored, start in next IDLE accepted
        do_start(3);
        repeat (10) @(posedge CLK);
        #1;
        chk("b2b_in_done", done, 1'b1);
        start = 1'b1; cell_num = AW'(2);
        @(posedge CLK); #1;
        t0 = cyc;
        @(posedge CLK); #1;
        start = 1'b0;
        observe(40, done_off, first_wr, n_wr, n_ez, busy_n, last_ez);
        chk("b2b_done_cycle", done_off, 10);
        chk("b2b_writes", n_wr, 2);

        // randomized starts, cell counts and occasional resets
        for (int i = 0; i < 600; i++) begin
            @(posedge CLK); #1;
            RST      = ($urandom_range(0, 199) == 0);
            start    = ($urandom_range(0, 3) == 0);
            cell_num = AW'($urandom_range(0, 20));
        end
        @(posedge CLK); #1;
        RST = 1'b0; start = 1'b0;
        for (int i = 0; i < 60 && busy; i++) @(posedge CLK);
        #1;
        chk("random_settled", busy, 1'b0);

        // largest sweep: all addresses, golden data on every write
        do_start(MEM - 1);
        observe(MEM + 40, done_off, first_wr, n_wr, n_ez, busy_n, last_ez);
        chk("full_writes", n_wr, MEM - 1);
        chk("full_ez_reads", n_ez, MEM);
        chk("full_last_ez", last_ez, 10'h3FF);
        chk("full_done_cycle", done_off, MEM - 1 + 2 + PL);

        repeat (4) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
